mem_arbiter: RTL and testbench

//  Shares the single simple-dual-port data memory between the instruction-fetch port (read-only)
//  and the load/store port (read/write). One request is granted per cycle, round-robin when both
//  are valid. A data-side lock holds the grant for read-modify-write sequences.

---
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one simple-dual-port memory between fetch (read) and load/store (read/write)
// Ports: clock/reset_n (sync, active-low); i_req_* / i_resp_* fetch port; d_req_* / d_resp_* / d_fault data port;
//        mem_* memory port signals (mem_rdata has 1-cycle latency). Widths: 0=byte 1=halfword 2=word.
// Optional: MEM_ARB_ALIGN_CHECK_EN enables misaligned data-request faulting.
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_req_valid,
  input  logic [XLEN-1:0] i_req_addr,
  output logic            i_req_ready,
  output logic            i_resp_valid,
  output logic [XLEN-1:0] i_resp_data,
  input  logic            d_req_valid,
  input  logic            d_req_write,
  input  logic            d_req_lock,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic [1:0]      d_req_width,
  input  logic            d_req_unsigned,
  input  logic [XLEN-1:0] d_req_wdata,
  output logic            d_req_ready,
  output logic            d_resp_valid,
  output logic [XLEN-1:0] d_resp_data,
  output logic            d_fault,
  output logic [XLEN-1:0] mem_raddr,
  output logic [XLEN-1:0] mem_waddr,
  output logic [1:0]      mem_wwidth,
  output logic            mem_wenable,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t state_q, state_d;
  logic rr_last_q, rr_last_d;
  logic resp_i_q, resp_i_d, resp_d_q, resp_d_d, resp_wr_q, resp_wr_d;
  logic resp_fault_q, resp_fault_d, resp_uns_q, resp_uns_d;
  logic [1:0] resp_width_q, resp_width_d;
  logic mis, sign;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign mis = ((d_req_width == 2'd1) & d_req_addr[0]) | ((d_req_width == 2'd2) & (d_req_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    d_req_ready = reset_n & d_req_valid & ((state_q == LOCKED) | ~i_req_valid | ~rr_last_q);
    i_req_ready = reset_n & i_req_valid & (state_q == ARB) & (~d_req_valid | rr_last_q);
    mem_raddr = d_req_ready ? d_req_addr : i_req_addr;
    mem_waddr = d_req_addr;
    mem_wdata = d_req_wdata;
    mem_wwidth = d_req_width;
    mem_wenable = d_req_ready & d_req_write & ~mis;
    rr_last_d = d_req_ready ? 1'b1 : i_req_ready ? 1'b0 : rr_last_q;
    state_d = d_req_ready ? (d_req_lock ? LOCKED : ARB) : state_q;
    resp_i_d = i_req_ready;
    resp_d_d = d_req_ready;
    resp_wr_d = d_req_write;
    resp_fault_d = d_req_ready & mis;
    resp_uns_d = d_req_unsigned;
    resp_width_d = d_req_width;
    i_resp_valid = reset_n & resp_i_q;
    i_resp_data = mem_rdata;
    d_resp_valid = reset_n & resp_d_q;
    d_fault = reset_n & resp_d_q & resp_fault_q;
    sign = ~resp_uns_q & (resp_width_q == 2'd0 ? mem_rdata[7] : mem_rdata[15]);
    d_resp_data = (resp_wr_q | resp_fault_q) ? '0 :
                  resp_width_q == 2'd0 ? {{(XLEN-8){sign}}, mem_rdata[7:0]} :
                  resp_width_q == 2'd1 ? {{(XLEN-16){sign}}, mem_rdata[15:0]} : mem_rdata;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ARB;
      rr_last_q <= 1'b0;
      resp_i_q <= 1'b0;
      resp_d_q <= 1'b0;
      resp_wr_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_uns_q <= 1'b0;
      resp_width_q <= 2'd0;
    end else begin
      state_q <= state_d;
      rr_last_q <= rr_last_d;
      resp_i_q <= resp_i_d;
      resp_d_q <= resp_d_d;
      resp_wr_q <= resp_wr_d;
      resp_fault_q <= resp_fault_d;
      resp_uns_q <= resp_uns_d;
      resp_width_q <= resp_width_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a behavioural 1-cycle-latency memory
module tb_mem_arbiter;
  logic        clock, reset_n;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_req_addr, i_resp_data;
  logic        d_req_valid, d_req_write, d_req_lock, d_req_unsigned, d_req_ready, d_resp_valid, d_fault;
  logic [1:0]  d_req_width, mem_wwidth;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        mem_wenable;
  logic [31:0] mem [0:255];
  int n_chk = 0;
  int n_pass = 0;
  logic exp_d;

  mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_lock(d_req_lock),
    .d_req_addr(d_req_addr), .d_req_width(d_req_width), .d_req_unsigned(d_req_unsigned),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data), .d_fault(d_fault),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wwidth(mem_wwidth),
    .mem_wenable(mem_wenable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wenable) mem[mem_waddr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_raddr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic dreq(input logic wr, input logic lk, input logic [31:0] a, input logic [1:0] w,
                      input logic u, input logic [31:0] wd);
    d_req_valid = 1'b1; d_req_write = wr; d_req_lock = lk; d_req_addr = a;
    d_req_width = w; d_req_unsigned = u; d_req_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;
    mem_rdata = 32'h0;
    reset_n = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    dreq(1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h1);
    step;
    step;
    #1;
    check("reset_i_ready", {31'b0, i_req_ready}, 32'h0);
    check("reset_d_ready", {31'b0, d_req_ready}, 32'h0);
    check("reset_wenable", {31'b0, mem_wenable}, 32'h0);
    check("reset_resp", {30'b0, i_resp_valid, d_resp_valid}, 32'h0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    step;
    reset_n = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    #1;
    check("fetch_ready", {30'b0, i_req_ready, d_req_ready}, 32'h2);
    check("fetch_raddr", mem_raddr, 32'h10);
    step;
    i_req_valid = 1'b0;
    #1;
    check("fetch_resp_valid", {30'b0, i_resp_valid, d_resp_valid}, 32'h2);
    check("fetch_resp_data", i_resp_data, 32'hDEADBEEF);
    i_req_valid = 1'b1;
    dreq(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    exp_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), {30'b0, i_req_ready, d_req_ready}, exp_d ? 32'h1 : 32'h2);
      step;
      check($sformatf("rr_resp%0d", k), {30'b0, i_resp_valid, d_resp_valid}, exp_d ? 32'h1 : 32'h2);
      if (exp_d) check("rr_load_data", d_resp_data, 32'hDEADBEEF);
      else check("rr_fetch_data", i_resp_data, 32'hDEADBEEF);
      exp_d = ~exp_d;
    end
    i_req_valid = 1'b0;
    dreq(1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h000080FF);
    #1;
    check("store_ready", {31'b0, d_req_ready}, 32'h1);
    check("store_wen", {31'b0, mem_wenable}, 32'h1);
    check("store_waddr", mem_waddr, 32'h20);
    check("store_wdata", mem_wdata, 32'h000080FF);
    step;
    dreq(1'b0, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0);
    #1;
    check("store_ack", {31'b0, d_resp_valid}, 32'h1);
    check("store_ack_data", d_resp_data, 32'h0);
    check("load_no_wen", {31'b0, mem_wenable}, 32'h0);
    step;
    dreq(1'b0, 1'b0, 32'h20, 2'd1, 1'b1, 32'h0);
    #1;
    check("lb_signed", d_resp_data, 32'hFFFFFFFF);
    step;
    dreq(1'b0, 1'b0, 32'h20, 2'd1, 1'b0, 32'h0);
    #1;
    check("lhu", d_resp_data, 32'h000080FF);
    step;
    d_req_valid = 1'b0;
    i_req_valid = 1'b1;
    #1;
    check("lh_signed", d_resp_data, 32'hFFFF80FF);
    check("lh_valid", {31'b0, d_resp_valid}, 32'h1);
    step;
    dreq(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0);
    #1;
    check("lock_grant1", {30'b0, i_req_ready, d_req_ready}, 32'h1);
    step;
    dreq(1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h12345678);
    #1;
    check("lock_grant2", {30'b0, i_req_ready, d_req_ready}, 32'h1);
    step;
    d_req_valid = 1'b0;
    #1;
    check("lock_release", {30'b0, i_req_ready, d_req_ready}, 32'h2);
    step;
    i_req_valid = 1'b0;
    dreq(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0);
    #1;
    check("rst_load_ready", {31'b0, d_req_ready}, 32'h1);
    step;
    reset_n = 1'b0;
    d_req_valid = 1'b0;
    #1;
    check("rst_mid_resp", {30'b0, i_resp_valid, d_resp_valid}, 32'h0);
    step;
    reset_n = 1'b1;
    i_req_valid = 1'b1;
    #1;
    check("rst_discard", {31'b0, d_resp_valid}, 32'h0);
    check("rst_unlocked", {31'b0, i_req_ready}, 32'h1);
    step;
    i_req_valid = 1'b0;
    dreq(1'b1, 1'b0, 32'h22, 2'd2, 1'b0, 32'hCAFEF00D);
    #1;
    check("mis_ready", {31'b0, d_req_ready}, 32'h1);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check("mis_wen", {31'b0, mem_wenable}, 32'h0);
`else
    check("mis_wen", {31'b0, mem_wenable}, 32'h1);
`endif
    step;
    d_req_valid = 1'b0;
    #1;
    check("mis_resp", {31'b0, d_resp_valid}, 32'h1);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check("mis_fault", {31'b0, d_fault}, 32'h1);
`else
    check("mis_fault", {31'b0, d_fault}, 32'h0);
`endif
    check("mis_data", d_resp_data, 32'h0);
    step;
    check("idle_resp", {30'b0, i_resp_valid, d_resp_valid}, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
